mmio_bus_fabric: RTL and testbench
==================================

MMIO_BUS_FABRIC -- requirements
Module: mmio_bus_fabric

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Parameter NUM_SLAVES SHALL default to 4 and set the number of peripheral slots (range 1..16).
REQ-003 Parameter REGION_BASE SHALL default to 32'hFFFF0000 and set the base of the peripheral region.
REQ-004 Parameter SLOT_LOG2 SHALL default to 4 and set the log2 of the slot size in bytes (16 bytes per slot).
REQ-005 Parameter TIMEOUT_CYCLES SHALL default to 16 and set the maximum slave wait, in cycles.
REQ-006 Port clk SHALL be an input, width 1: rising-edge clock.
REQ-007 Port rst SHALL be an input, width 1: asynchronous active-high reset.
REQ-008 Ports m_valid (in, 1), m_we (in, 1), m_addr (in, 32) and m_wdata (in, 32) SHALL form the master request.
REQ-009 Ports m_ready (out, 1), m_rdata (out, 32) and m_err (out, 1) SHALL form the master response.
REQ-010 Ports s_sel (out, NUM_SLAVES), s_we (out, 1), s_addr (out, 32) and s_wdata (out, 32) SHALL form the slot request; s_we, s_addr and s_wdata are broadcast to all slots.
REQ-011 Ports s_ready (in, NUM_SLAVES) and s_rdata (in, NUM_SLAVES*32) SHALL form the slot response; slot i occupies bits [32*i+31:32*i].
REQ-012 Ports mem_sel (out, 1), mem_ready (in, 1) and mem_rdata (in, 32) SHALL form the default data-memory port, sharing s_we, s_addr and s_wdata.
REQ-013 Port last_err_addr (out, 32) SHALL hold the address of the most recent errored transaction.

Function
REQ-014 Decode SHALL select slot i = (addr-REGION_BASE)>>SLOT_LOG2 when REGION_BASE <= addr < REGION_BASE+(NUM_SLAVES<<SLOT_LOG2), and the mem port otherwise.
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP, with IDLE entered on reset.
REQ-016 In IDLE, m_valid=1 SHALL latch m_we, m_addr, m_wdata and the decoded target at that edge, then transition to WAIT.
REQ-017 In WAIT, exactly one of s_sel/mem_sel SHALL be high, for the target only; s_we, s_addr and s_wdata SHALL be driven from the latched values.
REQ-018 A slot access with latched addr[1:0]!=0 SHALL go IDLE->RESP directly with m_err=1, assert no select, and leave the target untouched.
REQ-019 In WAIT, a sampled-high target ready SHALL capture the target rdata (reads) and transition to RESP; the select SHALL drop in that same transition.
REQ-020 In RESP, m_ready SHALL be high for exactly one cycle with m_rdata and m_err valid, and the FSM SHALL then return to IDLE.
REQ-021 Minimum latency SHALL be 2 cycles from the accepting edge to m_ready, for a target ready in its first WAIT cycle.
REQ-022 m_valid, m_addr, m_we and m_wdata SHALL be ignored outside IDLE; back-to-back requests SHALL be accepted in the IDLE cycle following RESP.
REQ-023 m_rdata SHALL be 0 for writes and for errored transactions.
REQ-024 last_err_addr SHALL update to the latched address at the edge entering RESP with m_err=1, and SHALL hold otherwise.
REQ-025 Readies from non-selected targets SHALL be ignored.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE and clear the wait counter.
REQ-027 rst=1 SHALL drive m_ready, m_err, s_sel, mem_sel and s_we to 0.
REQ-028 rst=1 SHALL drive m_rdata, s_addr, s_wdata and last_err_addr to 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no response.

Configuration
REQ-030 With macro MMIO_TIMEOUT_EN defined, a wait counter SHALL count cycles in WAIT, and TIMEOUT_CYCLES cycles without ready SHALL force RESP with m_err=1, the select dropped and last_err_addr updated.
REQ-031 With MMIO_TIMEOUT_EN undefined, the counter SHALL be absent and WAIT SHALL persist until ready; misalignment SHALL remain the only error source.

Verification
REQ-032 Read 0xFFFF0014, s_ready[1]=1 in first WAIT cycle, s_rdata slot1=0xCAFEF00D -> s_sel=4'b0010 for one cycle; m_ready at cycle 2; m_rdata=0xCAFEF00D; m_err=0.
REQ-033 Write 0x00001000 data 0x12345678, mem_ready after 3 WAIT cycles -> mem_sel high 3 cycles; s_we=1; s_wdata=0x12345678; m_rdata=0; m_err=0.
REQ-034 Read 0xFFFF0022 -> no select asserted; m_ready at cycle 1; m_err=1; last_err_addr=0xFFFF0022.
REQ-035 MMIO_TIMEOUT_EN defined, read 0xFFFF0030 with s_ready[3]=0 -> select low after 16 WAIT cycles; m_err=1; last_err_addr=0xFFFF0030.
REQ-036 Address 0xFFFF0040 (NUM_SLAVES=4) -> routed to mem port; rst pulse in WAIT -> all outputs 0 immediately and no m_ready.

Source files
------------

// File: rtl/mmio_bus_fabric.sv
// Single-master MMIO fabric: decodes a small peripheral region into NUM_SLAVES slots, everything else goes to the data-memory port.
// Optional slave-wait timeout is compiled in with `define MMIO_TIMEOUT_EN.
module mmio_bus_fabric #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] REGION_BASE    = 32'hFFFF0000,
  parameter int          SLOT_LOG2      = 4,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic                       m_we,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic                       m_err,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic                       s_we,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic                       mem_sel,
  input  logic                       mem_ready,
  input  logic [31:0]                mem_rdata,
  output logic [31:0]                last_err_addr
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [32:0] REGION_SIZE = 33'(NUM_SLAVES) << SLOT_LOG2;

  state_t state_reg, state_next;

  logic                  we_reg;
  logic [31:0]           addr_reg;
  logic [31:0]           wdata_reg;
  logic                  is_slot_reg;
  logic [NUM_SLAVES-1:0] hot_reg;
  logic [31:0]           rdata_reg;
  logic                  err_reg;
  logic [31:0]           last_err_reg;

  logic [31:0]           offset;
  logic                  in_region;
  logic [NUM_SLAVES-1:0] dec_hot;
  logic                  tgt_ready;
  logic [31:0]           tgt_rdata;
  logic                  load;
  logic                  to_resp;
  logic                  resp_err;
  logic [31:0]           resp_rdata;
  logic [31:0]           err_addr;

  // Incoming address decode; the 33-bit compare keeps a region touching the top of memory correct.
  assign offset    = m_addr - REGION_BASE;
  assign in_region = (m_addr >= REGION_BASE) && ({1'b0, offset} < REGION_SIZE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign dec_hot[gi] = in_region && ((offset >> SLOT_LOG2) == 32'(gi));
    end
  endgenerate

  // Only the latched target's ready/rdata are observed; all others are masked out.
  always_comb begin
    tgt_ready = 1'b0;
    tgt_rdata = 32'h0;
    if (!is_slot_reg) begin
      tgt_ready = mem_ready;
      tgt_rdata = mem_rdata;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (hot_reg[i]) begin
          tgt_ready = s_ready[i];
          tgt_rdata = s_rdata[32*i +: 32];
        end
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_hit;

  assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (state_reg != WAIT) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  logic        timeout_hit;
  logic [31:0] unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    to_resp    = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    err_addr   = addr_reg;
    case (state_reg)
      IDLE: begin
        err_addr = m_addr;
        if (m_valid) begin
          load = 1'b1;
          // Misaligned slot accesses are rejected without ever selecting the slot.
          if ((|dec_hot) && (m_addr[1:0] != 2'b00)) begin
            state_next = RESP;
            to_resp    = 1'b1;
            resp_err   = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (tgt_ready) begin
          state_next = RESP;
          to_resp    = 1'b1;
          resp_rdata = we_reg ? 32'h0 : tgt_rdata;
        end else if (timeout_hit) begin
          state_next = RESP;
          to_resp    = 1'b1;
          resp_err   = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg       <= 1'b0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      is_slot_reg  <= 1'b0;
      hot_reg      <= '0;
      rdata_reg    <= 32'h0;
      err_reg      <= 1'b0;
      last_err_reg <= 32'h0;
    end else begin
      if (load) begin
        we_reg      <= m_we;
        addr_reg    <= m_addr;
        wdata_reg   <= m_wdata;
        is_slot_reg <= |dec_hot;
        hot_reg     <= dec_hot;
      end
      if (to_resp) begin
        rdata_reg <= resp_rdata;
        err_reg   <= resp_err;
        if (resp_err) begin
          last_err_reg <= err_addr;
        end
      end
    end
  end

  assign m_ready       = (state_reg == RESP);
  assign m_rdata       = (state_reg == RESP) ? rdata_reg : 32'h0;
  assign m_err         = (state_reg == RESP) && err_reg;
  assign s_sel         = (state_reg == WAIT) ? hot_reg : '0;
  assign mem_sel       = (state_reg == WAIT) && !is_slot_reg;
  assign s_we          = (state_reg == WAIT) && we_reg;
  assign s_addr        = addr_reg;
  assign s_wdata       = wdata_reg;
  assign last_err_addr = last_err_reg;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed scoreboard bench for mmio_bus_fabric (default parameters; timeout case adapts to MMIO_TIMEOUT_EN).
module tb_mmio_bus_fabric;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m_valid = 1'b0;
  logic            m_we = 1'b0;
  logic [31:0]     m_addr = 32'h0;
  logic [31:0]     m_wdata = 32'h0;
  logic            m_ready;
  logic [31:0]     m_rdata;
  logic            m_err;
  logic [NS-1:0]   s_sel;
  logic            s_we;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [NS-1:0]   s_ready = '0;
  logic [NS*32-1:0] s_rdata = '0;
  logic            mem_sel;
  logic            mem_ready = 1'b0;
  logic [31:0]     mem_rdata = 32'h0;
  logic [31:0]     last_err_addr;

  mmio_bus_fabric dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .mem_sel(mem_sel), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lea;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_lea = 32'h0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // ready_n: WAIT cycle (1-based) in which the target raises ready; 0 = never.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ready_n, input logic [31:0] rdval);
    logic          is_slot, mis, tmo, exp_mem;
    int            idx, lat;
    logic [NS-1:0] exp_sel;
    exp_t          e, got;
    is_slot = (addr >= 32'hFFFF0000) && (addr < 32'hFFFF0040);
    idx     = int'((addr - 32'hFFFF0000) >> 4);
    mis     = is_slot && (addr[1:0] != 2'b00);
`ifdef MMIO_TIMEOUT_EN
    tmo     = !mis && (ready_n == 0 || ready_n > 16);
`else
    tmo     = 1'b0;
`endif
    exp_sel = (is_slot && !mis) ? NS'(1 << idx) : '0;
    exp_mem = !is_slot;
    e.err   = mis || tmo;
    e.rdata = (e.err || we) ? 32'h0 : rdval;
    if (e.err) exp_lea = addr;
    e.lea   = exp_lea;
    e.lat   = mis ? 1 : (tmo ? 17 : ready_n + 1);
    sb_q.push_back(e);

    // Non-target readies held high to show they are ignored.
    s_ready   = ~exp_sel;
    mem_ready = !exp_mem;
    for (int i = 0; i < NS; i++)
      s_rdata[32*i +: 32] = (is_slot && i == idx) ? rdval : $urandom;
    mem_rdata = exp_mem ? rdval : $urandom;

    m_valid = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    @(posedge clk); #1;
    m_addr = $urandom; m_wdata = $urandom; m_we = ~we;  // still valid: must be ignored
    lat = 1;
    while (!m_ready && lat < 60) begin
      chk("s_sel_wait", 32'(s_sel), 32'(exp_sel));
      chk("mem_sel_wait", 32'(mem_sel), 32'(exp_mem));
      if (lat == 1) begin
        chk("s_we", 32'(s_we), 32'(we));
        chk("s_addr", s_addr, addr);
        chk("s_wdata", s_wdata, wdata);
      end
      if (lat == ready_n) begin
        if (exp_mem) mem_ready = 1'b1;
        else s_ready = s_ready | exp_sel;
      end
      @(posedge clk); #1;
      s_ready = ~exp_sel; mem_ready = !exp_mem;
      lat++;
    end
    chk("m_ready", 32'(m_ready), 32'd1);
    if (m_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        got = sb_q.pop_front();
        chk("latency", 32'(lat), 32'(got.lat));
        chk("m_rdata", m_rdata, got.rdata);
        chk("m_err", 32'(m_err), 32'(got.err));
        chk("last_err_addr", last_err_addr, got.lea);
        chk("s_sel_resp", 32'(s_sel), 32'd0);
        chk("mem_sel_resp", 32'(mem_sel), 32'd0);
      end
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    chk("m_ready_one_cycle", 32'(m_ready), 32'd0);
    s_ready = '0; mem_ready = 1'b0;
    $display("txn we=%0d addr=%h wdata=%h ready_n=%0d -> lat=%0d", we, addr, wdata, ready_n, lat);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_ready"}, 32'(m_ready), 32'd0);
    chk({tag, "_m_err"}, 32'(m_err), 32'd0);
    chk({tag, "_s_sel"}, 32'(s_sel), 32'd0);
    chk({tag, "_mem_sel"}, 32'(mem_sel), 32'd0);
    chk({tag, "_s_we"}, 32'(s_we), 32'd0);
    chk({tag, "_m_rdata"}, m_rdata, 32'd0);
    chk({tag, "_s_addr"}, s_addr, 32'd0);
    chk({tag, "_s_wdata"}, s_wdata, 32'd0);
    chk({tag, "_last_err_addr"}, last_err_addr, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b0, 32'hFFFF0014, 32'h0, 1, 32'hCAFEF00D);
    run_txn(1'b1, 32'h00001000, 32'h12345678, 3, 32'h55AA55AA);
    run_txn(1'b0, 32'hFFFF0022, 32'h0, 1, 32'h11111111);
`ifdef MMIO_TIMEOUT_EN
    run_txn(1'b0, 32'hFFFF0030, 32'h0, 0, 32'h22222222);
`else
    run_txn(1'b0, 32'hFFFF0030, 32'h0, 20, 32'hA5A5A5A5);
`endif
    run_txn(1'b0, 32'hFFFF003C, 32'h0, 2, 32'h3C3C3C3C);
    run_txn(1'b0, 32'hFFFF0000, 32'h0, 1, 32'h00C0FFEE);
    run_txn(1'b1, 32'hFFFF0008, 32'hDEADBEEF, 2, 32'h77777777);
    run_txn(1'b0, 32'hFFFF0040, 32'h0, 1, 32'h0BADBEEF);
    run_txn(1'b0, 32'hFFFEFFFC, 32'h0, 2, 32'h13579BDF);
    run_txn(1'b1, 32'hFFFF0001, 32'h99999999, 1, 32'h0);

    // Reset pulse in WAIT aborts the transaction.
    m_valid = 1'b1; m_we = 1'b0; m_addr = 32'hFFFF0040; m_wdata = 32'h0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    chk("rst_pre_mem_sel", 32'(mem_sel), 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_mid");
    $display("reset asserted during WAIT");
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_lea = 32'h0;
    for (int c = 0; c < 5; c++) begin
      chk("no_resp_after_rst", 32'(m_ready), 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;

    run_txn(1'b0, 32'hFFFF0014, 32'h0, 1, 32'h600DF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
